// File: rtl/if_mem_ctrl_pkg.sv
// Shared definitions for the instruction-fetch memory controller:
// bus widths, the number of bytes per instruction and the FSM state encoding.
package if_mem_ctrl_pkg;

   localparam int INST_ADDR_BUS  = 32;
   localparam int INST_BUS       = 32;
   localparam int BYTES_PER_INST = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/if_mem_ctrl_byte_asm.sv
// Little-endian assembly register: one byte lane per instruction byte, written
// by index during a fetch, loaded whole on a buffer hit, cleared by flush.
module if_byte_asm
   import if_mem_ctrl_pkg::*;
#(
   parameter int INST_W = INST_BUS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              cap_en,
   input  logic [1:0]        cap_idx,
   input  logic [7:0]        cap_byte,
   input  logic              load_en,
   input  logic [INST_W-1:0] load_word,
   output logic [INST_W-1:0] inst
);

   localparam int NLANE = INST_W / 8;

   logic [7:0] lane_q [NLANE];

   genvar gi;
   generate
      for (gi = 0; gi < NLANE; gi++) begin : g_lane
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               lane_q[gi] <= '0;
            end else if (clr) begin
               lane_q[gi] <= '0;
            end else if (load_en) begin
               lane_q[gi] <= load_word[8*gi +: 8];
            end else if (cap_en && cap_idx == 2'(gi)) begin
               lane_q[gi] <= cap_byte;
            end
         end
         assign inst[8*gi +: 8] = lane_q[gi];
      end
   endgenerate

endmodule

// File: rtl/if_mem_ctrl.sv
// Instruction-fetch responder: four byte reads per fetch, assembled little-endian.
// Optional one-entry last-instruction buffer enabled by defining IF_LASTHIT_EN.
module if_mem_ctrl
   import if_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = INST_ADDR_BUS,
   parameter int INST_W = INST_BUS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   input  logic              ce,
   input  logic              flush,
   output logic [INST_W-1:0] inst,
   output logic              inst_valid,
   output logic              stall_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_din
);

   state_e            state_q;
   logic [2:0]        cnt_q;
   logic [2:0]        cnt_m1;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic              hit;
   logic              load_en;
   logic [INST_W-1:0] load_word;
   logic              unused_pc_lsb;

   assign addr_d        = {pc[ADDR_W-1:2], 2'b00};
   assign unused_pc_lsb = &{1'b0, pc[1:0]};
   assign cnt_m1        = cnt_q - 3'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
      end else if (flush) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (cnt_q == 3'(BYTES_PER_INST)) begin
                  state_q <= ST_DONE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            // IDLE and DONE share the accept logic; a buffer hit skips FETCH.
            default: begin
               if (hit) begin
                  addr_q  <= addr_d;
                  state_q <= ST_DONE;
               end else if (ce) begin
                  addr_q  <= addr_d;
                  cnt_q   <= '0;
                  state_q <= ST_FETCH;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end

`ifdef IF_LASTHIT_EN
   logic [ADDR_W-1:0] tag_q;
   logic [INST_W-1:0] data_q;
   logic              hit_v_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_q   <= '0;
         data_q  <= '0;
         hit_v_q <= 1'b0;
      end else if (state_q == ST_DONE && !flush) begin
         tag_q   <= addr_q;
         data_q  <= inst;
         hit_v_q <= 1'b1;
      end
   end

   assign hit       = ce && hit_v_q && (addr_d == tag_q);
   assign load_word = data_q;
`else
   assign hit       = 1'b0;
   assign load_word = '0;
`endif

   assign load_en = hit && !flush && (state_q != ST_FETCH);

   if_byte_asm #(
      .INST_W (INST_W)
   ) u_byte_asm (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .cap_en    (state_q == ST_FETCH && cnt_q != 3'd0),
      .cap_idx   (cnt_m1[1:0]),
      .cap_byte  (mem_din),
      .load_en   (load_en),
      .load_word (load_word),
      .inst      (inst)
   );

   assign mem_rd     = (state_q == ST_FETCH) && (cnt_q < 3'(BYTES_PER_INST));
   assign mem_addr   = (state_q == ST_FETCH) ? addr_q + ADDR_W'(cnt_q) : addr_q;
   assign inst_valid = (state_q == ST_DONE) && !flush;
   assign stall_req  = ce && (state_q != ST_DONE);

endmodule

// File: tb/tb_if_mem_ctrl.sv
// Directed bench for if_mem_ctrl: vector table of fetches plus hand sequences for
// back-to-back, flush, async reset and (with IF_LASTHIT_EN) buffer hits.
module tb_if_mem_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        ce;
   logic        flush;
   logic [31:0] inst;
   logic        inst_valid;
   logic        stall_req;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_din;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      int          lat;
      int          reads;
      string       nm;
   } vec_t;

   vec_t vecs [5];

   if_mem_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .ce         (ce),
      .flush      (flush),
      .inst       (inst),
      .inst_valid (inst_valid),
      .stall_req  (stall_req),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_din    (mem_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte memory: 0x100..0x103 hold an addi encoding, everything else addr+0x11.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'h100: return 8'h13;
         32'h101: return 8'h00;
         32'h102: return 8'h50;
         32'h103: return 8'h00;
         default: return a[7:0] + 8'h11;
      endcase
   endfunction

   always @(posedge clk) begin
      if (mem_rd) mem_din <= mem_byte(mem_addr);
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, got, exp);
      end else begin
         $display("ok   %s = %h", nm, got);
      end
   endtask

   task automatic do_fetch(input logic [31:0] p, input logic [31:0] exp_inst,
                           input int exp_lat, input int exp_reads, input string nm);
      int          lat;
      int          reads;
      int          stalls;
      logic [31:0] got;
      logic [31:0] base;
      logic        addr_ok;
      base    = {p[31:2], 2'b00};
      lat     = 0;
      reads   = 0;
      stalls  = 0;
      got     = '0;
      addr_ok = 1'b1;
      @(posedge clk); #1;
      pc = p;
      ce = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (inst_valid) begin
            lat = k;
            got = inst;
            break;
         end
         if (mem_rd) begin
            if (mem_addr !== base + 32'(reads)) addr_ok = 1'b0;
            reads++;
         end
         if (stall_req) stalls++;
      end
      ce = 1'b0;
      chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
      chk({nm, " inst"}, got, exp_inst);
      chk({nm, " reads"}, 32'(reads), 32'(exp_reads));
      chk({nm, " addr_seq"}, {31'd0, addr_ok}, 32'd1);
      chk({nm, " stall_cycles"}, 32'(stalls), 32'(exp_lat - 1));
      @(negedge clk);
      chk({nm, " single_pulse"}, {31'd0, inst_valid}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{pc: 32'h0000_0100, inst: 32'h0050_0013, lat: 6, reads: 4, nm: "f100"};
      vecs[1] = '{pc: 32'h0000_0020, inst: 32'h3433_3231, lat: 6, reads: 4, nm: "f020"};
      vecs[2] = '{pc: 32'hFFFF_FFFC, inst: 32'h100F_0E0D, lat: 6, reads: 4, nm: "fwrap"};
      vecs[3] = '{pc: 32'h0000_0103, inst: 32'h0050_0013, lat: 6, reads: 4, nm: "f103"};
      vecs[4] = '{pc: 32'h0000_0040, inst: 32'h5453_5251, lat: 6, reads: 4, nm: "f040"};

      rst   = 1'b0;
      ce    = 1'b0;
      flush = 1'b0;
      pc    = '0;
      #1;
      chk("reset inst", inst, 32'h0);
      chk("reset ctl", {28'd0, inst_valid, stall_req, mem_rd, 1'b0}, 32'h0);
      chk("reset mem_addr", mem_addr, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 5; i++) begin
         do_fetch(vecs[i].pc, vecs[i].inst, vecs[i].lat, vecs[i].reads, vecs[i].nm);
      end

`ifdef IF_LASTHIT_EN
      do_fetch(32'h40, 32'h5453_5251, 1, 0, "lasthit040");
`else
      do_fetch(32'h40, 32'h5453_5251, 6, 4, "refetch040");
`endif

      // Back-to-back: ce held high, pc advanced in each DONE cycle.
      begin
         logic [31:0] pcs  [3];
         logic [31:0] exps [3];
         int idx;
         int last;
         int stall_bad;
         pcs[0]  = 32'h0; pcs[1]  = 32'h4; pcs[2]  = 32'h8;
         exps[0] = 32'h1413_1211; exps[1] = 32'h1817_1615; exps[2] = 32'h1C1B_1A19;
         idx = 0;
         last = 0;
         stall_bad = 0;
         @(posedge clk); #1;
         pc = pcs[0];
         ce = 1'b1;
         for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (stall_req !== (ce && !inst_valid)) stall_bad++;
            if (inst_valid) begin
               chk($sformatf("b2b inst%0d", idx), inst, exps[idx]);
               if (idx > 0) chk($sformatf("b2b gap%0d", idx), 32'(cyc - last), 32'd6);
               last = cyc;
               idx++;
               if (idx == 3) begin
                  ce = 1'b0;
                  break;
               end
               pc = pcs[idx];
            end
         end
         ce = 1'b0;
         chk("b2b count", 32'(idx), 32'd3);
         chk("b2b stall_pattern", 32'(stall_bad), 32'd0);
         @(negedge clk);
      end

      // Flush at cnt=2: no valid, assembly cleared, next fetch intact.
      begin
         int valids;
         int reads;
         valids = 0;
         reads  = 0;
         @(posedge clk); #1;
         pc = 32'h100;
         ce = 1'b1;
         @(posedge clk);
         @(negedge clk);
         @(negedge clk);
         @(negedge clk);
         flush = 1'b1;
         if (inst_valid) valids++;
         @(posedge clk); #1;
         flush = 1'b0;
         ce    = 1'b0;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (inst_valid) valids++;
            if (mem_rd) reads++;
         end
         chk("flush no_valid", 32'(valids), 32'd0);
         chk("flush no_reads", 32'(reads), 32'd0);
         chk("flush inst_cleared", inst, 32'h0);
         do_fetch(32'h20, 32'h3433_3231, 6, 4, "postflush020");
      end

      // Async reset while cnt=3, applied between clock edges.
      begin
         int valids;
         int reads;
         valids = 0;
         reads  = 0;
         @(posedge clk); #1;
         pc = 32'h100;
         ce = 1'b1;
         @(posedge clk);
         for (int k = 0; k < 4; k++) @(negedge clk);
         chk("areset pre mem_rd", {31'd0, mem_rd}, 32'd1);
         #1;
         rst = 1'b0;
         ce  = 1'b0;
         #1;
         chk("areset mem_rd", {31'd0, mem_rd}, 32'd0);
         chk("areset stall_req", {31'd0, stall_req}, 32'd0);
         chk("areset inst_valid", {31'd0, inst_valid}, 32'd0);
         chk("areset mem_addr", mem_addr, 32'h0);
         @(negedge clk);
         rst = 1'b1;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (inst_valid) valids++;
            if (mem_rd) reads++;
         end
         chk("areset idle_valid", 32'(valids), 32'd0);
         chk("areset idle_reads", 32'(reads), 32'd0);
         do_fetch(32'h100, 32'h0050_0013, 6, 4, "postreset100");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/if_mem_ctrl.md
Name: if_mem_ctrl

Overview:
- Responder side of the instruction-fetch interface: accepts pc/ce from the PC generator and returns the 32-bit instruction.
- Reads an 8-bit synchronous memory four times per fetch and assembles the bytes little-endian.
- Raises stall_req so the PC generator holds pc until the instruction is delivered.
- Sits between the PC generator / IF-ID stage and the byte-wide memory port.

Parameters:
- ADDR_W, 32: width of pc and mem_addr.
- INST_W, 32: instruction width. Fixed at 32; 4 bytes per fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  fetch address from the PC generator.
- ce  in  1  fetch enable; registered upstream.
- flush  in  1  synchronous abort (branch/jump redirect).
- inst  out  INST_W  assembled instruction.
- inst_valid  out  1  inst is valid this cycle.
- stall_req  out  1  hold the PC generator.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_rd  out  1  memory read strobe.
- mem_din  in  8  read data, valid one cycle after mem_rd/mem_addr.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, addr_q=0, inst=0, inst_valid=0, mem_rd=0, mem_addr=0, stall_req=0.
- States: IDLE, FETCH, DONE. cnt is 3 bits, range 0..4.
- IDLE:
  - If ce=1 at an edge: addr_q <= {pc[ADDR_W-1:2],2'b00}, cnt <= 0, state <= FETCH.
  - pc[1:0] is ignored.
- FETCH:
  - mem_rd = (cnt<4); mem_addr = addr_q + cnt, wrapping mod 2^ADDR_W.
  - Every edge: cnt++. If cnt>=1, inst[8*(cnt-1)+:8] <= mem_din.
  - At the edge with cnt==4: state <= DONE.
- DONE:
  - inst_valid = !flush; inst is held stable.
  - Next edge: if ce=1, start a new fetch (latch pc, cnt=0, FETCH); otherwise go to IDLE.
- stall_req = ce && (state != DONE). It is combinational; there is no loop because ce is registered upstream.
- The PC generator advances exactly on the DONE edge.
- Timing: latency from the accept edge to inst_valid is 6 cycles. Back-to-back throughput is one instruction per 6 cycles.
- Outside FETCH: mem_rd=0 and mem_addr holds addr_q.
- flush=1 at any edge: state <= IDLE, cnt <= 0. Partially assembled bytes are discarded and inst_valid is not raised for that fetch.
- flush has priority over ce in IDLE and DONE.
- ce dropping mid-FETCH: the fetch completes. DONE then goes to IDLE and stall_req=0 throughout.
- Async reset mid-FETCH: all outputs return to reset values immediately. No partial inst_valid is produced.

Optional Feature:
- Macro IF_LASTHIT_EN.
- Enabled: a one-entry last-instruction buffer (tag_q, data_q, hit_v).
  - Written on every DONE that is not flushed.
  - In IDLE or DONE, if ce && hit_v && aligned pc==tag_q: state <= DONE directly with inst <= data_q, a 1-cycle turnaround.
  - hit_v is cleared only by reset.
- Disabled: no buffer; every fetch performs four memory reads.

Decomposition:
- Shared defines package: state encodings (IDLE/FETCH/DONE), InstAddrBus/InstBus widths, byte count constant 4.
- Natural sub-module: if_byte_asm, holding the cnt-indexed byte shift/assembly register with clear-on-flush.
- The FSM stays in if_mem_ctrl.

Test Plan:
- Single fetch: memory holds bytes 13,00,50,00 at 0x100; pc=0x100, ce=1 for one accept → mem_addr 0x100..0x103 on consecutive cycles; inst=0x00500013, inst_valid for exactly 1 cycle, 6 cycles after accept; stall_req high for 5 cycles.
- Back-to-back: ce held high, pc steps 0x0,0x4,0x8 → three inst_valid pulses 6 cycles apart; stall_req deasserts only in DONE cycles.
- Flush in FETCH at cnt=2 → no inst_valid; the next accept of pc=0x20 returns the word at 0x20 intact, with no stale bytes.
- Wrap: pc=0xFFFFFFFC → mem_addr 0xFFFFFFFC..0xFFFFFFFF, no carry into a new address; pc=0x103 fetches 0x100.
- Async reset (rst=0) asserted while cnt=3 → mem_rd, stall_req, inst_valid go to 0 without waiting for clk; after release, the block is in IDLE.
- IF_LASTHIT_EN: fetch 0x40, then re-request 0x40 → mem_rd stays 0 and inst_valid arrives 1 cycle after accept with the same word.
